// File: rtl/pipa_pulse_accumulator.sv
// PIPA pulse accumulator: synchronises plus/minus accelerometer pulses, keeps a saturating signed
// backlog per channel and drains it to the counter-increment sequencer over a req/ack handshake.
module pipa_pulse_accumulator #(
    parameter int unsigned NCH  = 3,
    parameter int unsigned CW   = 4,
    parameter int unsigned SYNC = 2,
    parameter int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLOCK,
    input  logic           rst_,
    input  logic [NCH-1:0] PIPP,
    input  logic [NCH-1:0] PIPM,
    input  logic           CNTACK,
    input  logic           OVFCLR,
    output logic           CNTREQ,
    output logic           CNTDIR,
    output logic [CHW-1:0] CNTCH,
    output logic [NCH-1:0] OVF,
    output logic           PEND0
);

    localparam int unsigned SupW = $clog2(SYNC + 2);
    localparam logic [SupW-1:0] SupInit = SupW'(SYNC + 1);

    // Sums are formed two bits wider so a +/-2 step past the bound is visible before clamping.
    localparam logic signed [CW+1:0] CntMax  = (CW+2)'((1 << (CW - 1)) - 1);
    localparam logic signed [CW+1:0] CntMin  = -CntMax;
    localparam logic signed [CW+1:0] One     = (CW+2)'(1);
    localparam logic signed [CW-1:0] CntMaxN = CW'((1 << (CW - 1)) - 1);
    localparam logic signed [CW-1:0] CntMinN = -CntMaxN;

    typedef enum logic [0:0] {
        StIdle,
        StReq
    } state_e;

    logic [SYNC-1:0][NCH-1:0] psync_q, msync_q;
    logic [NCH-1:0]           pprev_q, mprev_q;
    logic [NCH-1:0]           pev_d, mev_d, pev_q, mev_q;
    logic [SupW-1:0]          sup_q;
    logic                     sup_off;

    logic signed [CW-1:0]     cnt_q [NCH];
    logic signed [CW-1:0]     cnt_d [NCH];
    logic [NCH-1:0]           sat_set;
    logic [NCH-1:0]           ovf_q, ovf_d;
    logic                     pend0_q, pend0_d;

    state_e                   state_q, state_d;
    logic [CHW-1:0]           cntch_q, cntch_d;
    logic                     cntdir_q, cntdir_d;
    logic [CHW-1:0]           ptr_q, ptr_d;
    logic                     ack_fire;

    logic                     sel_found;
    logic [CHW-1:0]           sel_ch;
    logic                     sel_dir;

    // ------------------------------------------------------------------
    // Synchronisers and rising-edge detection
    // ------------------------------------------------------------------
    // Edges are masked until the previous-value flops have caught up with lines held high
    // through reset.
    assign sup_off = (sup_q == '0);
    assign pev_d   = psync_q[SYNC-1] & ~pprev_q & {NCH{sup_off}};
    assign mev_d   = msync_q[SYNC-1] & ~mprev_q & {NCH{sup_off}};

    always_ff @(posedge CLOCK) begin
        if (!rst_) begin
            psync_q <= '0;
            msync_q <= '0;
            pprev_q <= '0;
            mprev_q <= '0;
            pev_q   <= '0;
            mev_q   <= '0;
            sup_q   <= SupInit;
        end else begin
            psync_q <= {psync_q[SYNC-2:0], PIPP};
            msync_q <= {msync_q[SYNC-2:0], PIPM};
            pprev_q <= psync_q[SYNC-1];
            mprev_q <= msync_q[SYNC-1];
            pev_q   <= pev_d;
            mev_q   <= mev_d;
            if (!sup_off) begin
                sup_q <= sup_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending counters with saturation
    // ------------------------------------------------------------------
    assign ack_fire = (state_q == StReq) && CNTACK;

    always_comb begin : cnt_update
        logic signed [CW+1:0] delta;
        logic signed [CW+1:0] sum;
        delta   = '0;
        sum     = '0;
        sat_set = '0;
        pend0_d = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            delta = '0;
            if (pev_q[c] && !mev_q[c]) begin
                delta = One;
            end else if (mev_q[c] && !pev_q[c]) begin
                delta = -One;
            end
            // A served PINC removes one pending plus count, a served MINC one minus count.
            if (ack_fire && (cntch_q == CHW'(c))) begin
                delta = cntdir_q ? (delta - One) : (delta + One);
            end
            sum = {{2{cnt_q[c][CW-1]}}, cnt_q[c]} + delta;
            if (sum > CntMax) begin
                cnt_d[c]   = CntMaxN;
                sat_set[c] = 1'b1;
            end else if (sum < CntMin) begin
                cnt_d[c]   = CntMinN;
                sat_set[c] = 1'b1;
            end else begin
                cnt_d[c] = sum[CW-1:0];
            end
            if (cnt_d[c] != '0) begin
                pend0_d = 1'b0;
            end
        end
    end

    // Set wins over a coincident clear.
    assign ovf_d = (ovf_q & ~{NCH{OVFCLR}}) | sat_set;

    // ------------------------------------------------------------------
    // Round-robin pick of the first nonzero channel at or after the pointer
    // ------------------------------------------------------------------
    always_comb begin : rr_pick
        int             idx;
        logic [CHW-1:0] cand;
        idx       = 0;
        cand      = '0;
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_dir   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx  = (int'(ptr_q) + i) % int'(NCH);
            cand = CHW'(idx);
            if (!sel_found && (cnt_d[cand] != '0)) begin
                sel_found = 1'b1;
                sel_ch    = cand;
                sel_dir   = ~cnt_d[cand][CW-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cntch_d  = cntch_q;
        cntdir_d = cntdir_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d  = StReq;
                    cntch_d  = sel_ch;
                    cntdir_d = sel_dir;
                end
            end
            StReq: begin
                if (ack_fire) begin
                    state_d = StIdle;
                    ptr_d   = (cntch_q == CHW'(NCH - 1)) ? '0 : (cntch_q + 1'b1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!rst_) begin
            state_q  <= StIdle;
            cntch_q  <= '0;
            cntdir_q <= 1'b0;
            ptr_q    <= '0;
            ovf_q    <= '0;
            pend0_q  <= 1'b1;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cntch_q  <= cntch_d;
            cntdir_q <= cntdir_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            pend0_q  <= pend0_d;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CNTREQ = (state_q == StReq);
    assign CNTDIR = cntdir_q;
    assign OVF    = ovf_q;
    assign PEND0  = pend0_q;

    if (NCH == 1) begin : g_single
        assign CNTCH = '0;
    end else begin : g_multi
        assign CNTCH = cntch_q;
    end

endmodule

// File: tb/tb_pipa_pulse_accumulator.sv
// Directed bench for pipa_pulse_accumulator (NCH=3, CW=4, SYNC=2): table-driven pulse vectors
// plus hand-written sequences for round-robin, zero crossing, saturation and reset corners.
module tb_pipa_pulse_accumulator;

    localparam int NCH  = 3;
    localparam int CW   = 4;
    localparam int SYNC = 2;
    localparam int CHW  = 2;

    logic           CLOCK;
    logic           rst_;
    logic [NCH-1:0] PIPP;
    logic [NCH-1:0] PIPM;
    logic           CNTACK;
    logic           OVFCLR;
    logic           CNTREQ;
    logic           CNTDIR;
    logic [CHW-1:0] CNTCH;
    logic [NCH-1:0] OVF;
    logic           PEND0;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [2:0] pipp;
        logic [2:0] pipm;
        logic       req;
        logic [1:0] ch;
        logic       dir;
        logic       pend0;
    } vec_t;

    vec_t vecs [7];

    pipa_pulse_accumulator #(
        .NCH  (NCH),
        .CW   (CW),
        .SYNC (SYNC),
        .CHW  (CHW)
    ) dut (
        .CLOCK  (CLOCK),
        .rst_   (rst_),
        .PIPP   (PIPP),
        .PIPM   (PIPM),
        .CNTACK (CNTACK),
        .OVFCLR (OVFCLR),
        .CNTREQ (CNTREQ),
        .CNTDIR (CNTDIR),
        .CNTCH  (CNTCH),
        .OVF    (OVF),
        .PEND0  (PEND0)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ack everything until the backlog is empty; a blown budget counts as a failure.
    task automatic drain(input string name);
        logic done;
        done   = 1'b0;
        CNTACK = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (!CNTREQ && PEND0) begin
                done = 1'b1;
                break;
            end
        end
        CNTACK = 1'b0;
        tick(1);
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin : main
        logic [2:0] rr_log [8];
        logic [2:0] rr_exp [4];
        int         nlog;
        int         nack;

        n_chk  = 0;
        n_fail = 0;
        rst_   = 1'b0;
        PIPP   = '0;
        PIPM   = '0;
        CNTACK = 1'b0;
        OVFCLR = 1'b0;

        //                pipp    pipm    req   ch     dir   pend0
        vecs[0] = '{3'b010, 3'b000, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[1] = '{3'b000, 3'b100, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[2] = '{3'b001, 3'b001, 1'b0, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{3'b101, 3'b000, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[4] = '{3'b000, 3'b011, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[5] = '{3'b001, 3'b000, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[6] = '{3'b010, 3'b110, 1'b1, 2'd2, 1'b0, 1'b0};

        // Reset state
        tick(3);
        chk("rst_cntreq", 32'(CNTREQ), 32'd0);
        chk("rst_cntdir", 32'(CNTDIR), 32'd0);
        chk("rst_cntch", 32'(CNTCH), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        chk("rst_pend0", 32'(PEND0), 32'd1);
        rst_ = 1'b1;
        tick(6);

        // Single pulse: request appears SYNC+2 edges after the input edge
        PIPP = 3'b010;
        tick(3);
        PIPP = '0;
        chk("sp_req_early", 32'(CNTREQ), 32'd0);
        tick(1);
        chk("sp_req", 32'(CNTREQ), 32'd1);
        chk("sp_ch", 32'(CNTCH), 32'd1);
        chk("sp_dir", 32'(CNTDIR), 32'd1);
        chk("sp_pend0_busy", 32'(PEND0), 32'd0);
        CNTACK = 1'b1;
        tick(1);
        CNTACK = 1'b0;
        chk("sp_req_after_ack", 32'(CNTREQ), 32'd0);
        chk("sp_pend0_after_ack", 32'(PEND0), 32'd1);
        tick(4);
        chk("sp_req_quiet", 32'(CNTREQ), 32'd0);

        // Table-driven single-shot patterns
        for (int v = 0; v < 7; v++) begin
            PIPP = vecs[v].pipp;
            PIPM = vecs[v].pipm;
            tick(2);
            PIPP = '0;
            PIPM = '0;
            tick(2);
            chk($sformatf("vec%0d_req", v), 32'(CNTREQ), 32'(vecs[v].req));
            if (vecs[v].req) begin
                chk($sformatf("vec%0d_ch", v), 32'(CNTCH), 32'(vecs[v].ch));
                chk($sformatf("vec%0d_dir", v), 32'(CNTDIR), 32'(vecs[v].dir));
            end
            chk($sformatf("vec%0d_pend0", v), 32'(PEND0), 32'(vecs[v].pend0));
            chk($sformatf("vec%0d_ovf", v), 32'(OVF), 32'd0);
            drain($sformatf("vec%0d_drain", v));
        end

        // Round-robin with CNTACK tied high
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b011;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        for (int i = 0; i < 8; i++) begin
            rr_log[i] = '0;
        end
        nlog   = 0;
        CNTACK = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 0) begin
                PIPP = 3'b011;
                PIPM = 3'b100;
            end else if (k == 2 || k == 6) begin
                PIPP = '0;
                PIPM = '0;
            end else if (k == 4) begin
                PIPP = 3'b001;
            end
            tick(1);
            if (CNTREQ && nlog < 8) begin
                rr_log[nlog] = {CNTCH, CNTDIR};
                nlog++;
            end
        end
        CNTACK = 1'b0;
        chk("rr_count", 32'(nlog), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_req%0d", i), 32'(rr_log[i]), 32'(rr_exp[i]));
        end
        chk("rr_pend0", 32'(PEND0), 32'd1);

        // Zero crossing: opposite edge while the request is held
        PIPP = 3'b001;
        tick(2);
        PIPP = '0;
        tick(2);
        chk("xz_req", 32'(CNTREQ), 32'd1);
        chk("xz_ch", 32'(CNTCH), 32'd0);
        chk("xz_dir", 32'(CNTDIR), 32'd1);
        PIPM = 3'b001;
        tick(2);
        PIPM = '0;
        tick(3);
        chk("xz_req_held", 32'(CNTREQ), 32'd1);
        chk("xz_dir_held", 32'(CNTDIR), 32'd1);
        chk("xz_pend0_zero", 32'(PEND0), 32'd1);
        CNTACK = 1'b1;
        tick(1);
        CNTACK = 1'b0;
        chk("xz_req_gap", 32'(CNTREQ), 32'd0);
        chk("xz_pend0_neg", 32'(PEND0), 32'd0);
        tick(1);
        chk("xz_req2", 32'(CNTREQ), 32'd1);
        chk("xz_ch2", 32'(CNTCH), 32'd0);
        chk("xz_dir2", 32'(CNTDIR), 32'd0);
        drain("xz_drain");

        // Saturation on channel 2 with no acks
        for (int p = 0; p < 9; p++) begin
            PIPP = 3'b100;
            tick(2);
            PIPP = '0;
            tick(2);
            if (p == 6) begin
                chk("sat_ovf_at_max", 32'(OVF), 32'd0);
            end
        end
        tick(2);
        chk("sat_ovf_set", 32'(OVF), 32'b100);
        chk("sat_req", 32'(CNTREQ), 32'd1);
        chk("sat_ch", 32'(CNTCH), 32'd2);
        chk("sat_dir", 32'(CNTDIR), 32'd1);
        OVFCLR = 1'b1;
        tick(1);
        OVFCLR = 1'b0;
        chk("sat_ovf_clr", 32'(OVF), 32'd0);
        PIPP = 3'b100;
        tick(2);
        PIPP = '0;
        tick(1);
        OVFCLR = 1'b1;
        tick(1);
        OVFCLR = 1'b0;
        chk("sat_set_wins", 32'(OVF), 32'b100);
        nack = 0;
        for (int a = 0; a < 12; a++) begin
            for (int w = 0; w < 8; w++) begin
                if (CNTREQ) break;
                tick(1);
            end
            CNTACK = 1'b1;
            tick(1);
            CNTACK = 1'b0;
            nack++;
            if (PEND0) break;
        end
        chk("sat_clamp_acks", 32'(nack), 32'd7);
        OVFCLR = 1'b1;
        tick(1);
        OVFCLR = 1'b0;
        tick(2);

        // Line held high through reset release produces no event
        rst_ = 1'b0;
        PIPP = 3'b111;
        tick(3);
        chk("rsthi_req_in_rst", 32'(CNTREQ), 32'd0);
        rst_ = 1'b1;
        tick(10);
        chk("rsthi_req", 32'(CNTREQ), 32'd0);
        chk("rsthi_pend0", 32'(PEND0), 32'd1);
        PIPP = '0;
        tick(6);
        chk("rsthi_req_after_fall", 32'(CNTREQ), 32'd0);

        // Reset while a request is outstanding
        PIPP = 3'b010;
        tick(2);
        PIPP = '0;
        tick(2);
        chk("rstmid_req", 32'(CNTREQ), 32'd1);
        chk("rstmid_ch", 32'(CNTCH), 32'd1);
        rst_ = 1'b0;
        tick(1);
        chk("rstmid_req_drop", 32'(CNTREQ), 32'd0);
        chk("rstmid_ch_zero", 32'(CNTCH), 32'd0);
        chk("rstmid_pend0", 32'(PEND0), 32'd1);
        rst_ = 1'b1;
        tick(10);
        chk("rstmid_discarded", 32'(CNTREQ), 32'd0);
        chk("rstmid_pend0_after", 32'(PEND0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
